fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
Instruction fetch unit with an internal PC, a DEPTH-entry prefetch queue and redirect/flush support; it replaces the single-shot fetcher between the bus master and the decoder. It issues sequential word fetches whenever the queue has credit, buffers the returned instructions, and drains them to the decoder over a valid/ready handshake. A redirect from execute flushes all prefetched state, discards any in-flight reply and restarts fetch at the new PC.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, 2..16
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
redirect_valid  in  1  flush and restart fetch at redirect_pc (from execute/branch)
redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
bus_start  out  1  request/hold a read transfer
bus_address  out  32  fetch address
bus_write  out  1  always 0
bus_available  in  1  bus free for a new transaction
bus_ready  in  1  device ready / reply valid
bus_error  in  1  reply is an error response (qualified by bus_ready while WAITING)
bus_read_data  in  32  returned instruction word
dec_valid  out  1  queue head valid
dec_ready  in  1  decoder accepts head
dec_instruction  out  32  head instruction
dec_address  out  32  head instruction address
dec_fault  out  1  head is a fetch fault (instruction field = 0)

Behaviour:
- Reset (async, nreset low): state IDLE, pc=RESET_PC, queue empty, bus_start=0, bus_address=0, bus_write=0, dec_valid=0, dec_instruction=0, dec_address=0, dec_fault=0.
- Queue: circular, DEPTH entries of {fault, address, instruction}; head/tail pointers wrap mod DEPTH; count 0..DEPTH. dec_* driven combinationally from head; dec_valid = (count!=0). Pop when dec_valid && dec_ready.
- Credit: issue only if count + inflight < DEPTH (inflight = 1 in WAITING). Never overflows.
- IDLE: if bus_available && bus_ready && credit && !redirect_valid -> next cycle bus_start=1, bus_address=pc, pc<=pc+PC_STEP (wraps modulo 2^32), go WAITING. Otherwise bus_start=0.
- WAITING: hold bus_start/bus_address until bus_ready. On bus_ready && !bus_error: push {0, addr, read_data}, bus_start<=0, go IDLE. On bus_ready && bus_error: push {1, addr, 0}, bus_start<=0, go HALTED.
- HALTED: no fetches until redirect; queue still drains.
- DISCARD: transfer in flight is unwanted; hold bus_start until bus_ready, drop reply (no push), go IDLE.
- Throughput: at most one outstanding transfer; one fetch per 2 cycles best case (issue, reply).
- Simultaneous push and pop in the same cycle: both occur, count unchanged; legal when full (pop frees the slot written that cycle).
- Redirect (any state, highest priority): queue flushed same cycle (count<=0, pointers<=0; a pop that cycle is ignored), pc<=redirect_pc with [1:0]=0. From WAITING, go DISCARD (the reply arriving in that same cycle is also dropped, go IDLE directly if bus_ready is high). From IDLE/HALTED/DISCARD go IDLE (DISCARD stays DISCARD if its reply has not arrived yet).
- No new fetch issued in the redirect cycle; first fetch at the new PC is no earlier than the following cycle.
- Reset mid-transfer: immediate return to reset values; any reply afterwards is ignored.

Optional Feature:
FETCH_PERF_COUNTERS_EN: when defined, adds outputs perf_fetched[31:0] (count of non-faulting replies pushed), perf_discarded[31:0] (count of replies dropped due to redirect) and perf_full_stall[31:0] (cycles in IDLE with bus free but no credit); all reset to 0 and saturate at 32'hFFFF_FFFF. When not defined these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, bus always ready with 1-cycle reply, dec_ready=1 -> fetch addresses 0,4,8,... in order; dec_address/dec_instruction match; no gaps beyond 2 cycles/instr.
- dec_ready=0, DEPTH=4 -> exactly 4 fetches issued, then bus_start stays 0; raising dec_ready for 1 cycle -> exactly one more fetch.
- Redirect to 0x100 while WAITING with 2 queued -> dec_valid=0 next cycle, late reply dropped, next bus_address=0x100.
- Redirect in the same cycle as bus_ready reply -> reply not pushed; next fetch at redirect_pc.
- bus_error on fetch at 0x8 -> entry with dec_fault=1, dec_address=0x8, instruction=0; no further bus_start until redirect_valid.
- Full queue with simultaneous pop and push -> count stays 4; order preserved across pointer wrap.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_prefetch_queue : sequential instruction fetcher with a DEPTH-entry
// prefetch queue and redirect flush. Option macro: FETCH_PERF_COUNTERS_EN
// Revision: 1.0
// ============================================================================
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        bus_start,
  output logic [31:0] bus_address,
  output logic        bus_write,
  input  logic        bus_available,
  input  logic        bus_ready,
  input  logic        bus_error,
  input  logic [31:0] bus_read_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instruction,
  output logic [31:0] dec_address,
  output logic        dec_fault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_full_stall
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_HALTED  = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               bus_start_q, bus_start_d;
  logic [31:0]        bus_address_q, bus_address_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        fifo_instr_q [DEPTH];
  logic [31:0]        fifo_instr_d [DEPTH];
  logic [31:0]        fifo_addr_q  [DEPTH];
  logic [31:0]        fifo_addr_d  [DEPTH];
  logic               fifo_fault_q [DEPTH];
  logic               fifo_fault_d [DEPTH];

  logic        credit;
  logic        pop;
  logic        push;
  logic        push_fault;
  logic [31:0] push_instr;
  logic        discard;

  assign credit    = (count_q < DEPTH_C);
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;

  assign bus_start       = bus_start_q;
  assign bus_address     = bus_address_q;
  assign bus_write       = 1'b0;
  assign dec_instruction = dec_valid ? fifo_instr_q[head_q] : 32'd0;
  assign dec_address     = dec_valid ? fifo_addr_q[head_q]  : 32'd0;
  assign dec_fault       = dec_valid ? fifo_fault_q[head_q] : 1'b0;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    bus_start_d   = bus_start_q;
    bus_address_d = bus_address_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_addr_d   = fifo_addr_q;
    fifo_fault_d  = fifo_fault_q;
    push          = 1'b0;
    push_fault    = 1'b0;
    push_instr    = 32'd0;
    discard       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_available && bus_ready && credit && !redirect_valid) begin
          bus_start_d   = 1'b1;
          bus_address_d = pc_q;
          pc_d          = pc_q + PC_STEP;
          state_d       = ST_WAITING;
        end
      end
      ST_WAITING: begin
        if (bus_ready) begin
          bus_start_d = 1'b0;
          if (redirect_valid) begin
            discard = 1'b1;
            state_d = ST_IDLE;
          end else begin
            push       = 1'b1;
            push_fault = bus_error;
            push_instr = bus_error ? 32'd0 : bus_read_data;
            state_d    = bus_error ? ST_HALTED : ST_IDLE;
          end
        end else if (redirect_valid) begin
          state_d = ST_DISCARD;
        end
      end
      ST_HALTED: begin
        if (redirect_valid) state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (bus_ready) begin
          bus_start_d = 1'b0;
          discard     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect wins over any push/pop in the same cycle.
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fifo_instr_d[tail_q] = push_instr;
        fifo_addr_d[tail_q]  = bus_address_q;
        fifo_fault_d[tail_q] = push_fault;
        tail_d               = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      bus_start_q   <= 1'b0;
      bus_address_q <= 32'd0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'd0;
        fifo_addr_q[i]  <= 32'd0;
        fifo_fault_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      bus_start_q   <= bus_start_d;
      bus_address_q <= bus_address_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_addr_q   <= fifo_addr_d;
      fifo_fault_q  <= fifo_fault_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;
  logic [31:0] perf_full_stall_q, perf_full_stall_d;

  always_comb begin
    perf_fetched_d    = perf_fetched_q;
    perf_discarded_d  = perf_discarded_q;
    perf_full_stall_d = perf_full_stall_q;
    if (push && !push_fault && (perf_fetched_q != 32'hFFFF_FFFF))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (discard && (perf_discarded_q != 32'hFFFF_FFFF))
      perf_discarded_d = perf_discarded_q + 32'd1;
    if ((state_q == ST_IDLE) && bus_available && !credit &&
        (perf_full_stall_q != 32'hFFFF_FFFF))
      perf_full_stall_d = perf_full_stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      perf_fetched_q    <= 32'd0;
      perf_discarded_q  <= 32'd0;
      perf_full_stall_q <= 32'd0;
    end else begin
      perf_fetched_q    <= perf_fetched_d;
      perf_discarded_q  <= perf_discarded_d;
      perf_full_stall_q <= perf_full_stall_d;
    end
  end

  assign perf_fetched    = perf_fetched_q;
  assign perf_discarded  = perf_discarded_q;
  assign perf_full_stall = perf_full_stall_q;
`endif

endmodule
`default_nettype wire
